// File: rtl/ariele_arb_pkg.sv
// Shared types and helpers for the ariele per-slave arbiter.
package ariele_arb_pkg;

  localparam int unsigned MAX_MASTERS  = 8;
  localparam int unsigned MAX_RD_DEPTH = 16;

  typedef logic [2:0] mid_t;

  typedef struct packed {
    logic vld;
    mid_t idx;
  } pick_t;

  // First set bit of req_mask at or after ptr, wrapping. Bits at or above the
  // active master count are expected to be zero, so a mod-8 wrap behaves as a
  // mod-N wrap for any ptr below N.
  function automatic pick_t rr_pick(input logic [MAX_MASTERS-1:0] req_mask, input mid_t ptr);
    pick_t r;
    mid_t  k;
    r.vld = 1'b0;
    r.idx = '0;
    // Scan from the farthest offset down so the closest match is kept last.
    for (int i = MAX_MASTERS - 1; i >= 0; i--) begin
      k = ptr + mid_t'(i);
      if (req_mask[k]) begin
        r.vld = 1'b1;
        r.idx = k;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ariele_arb_idfifo.sv
// In-order FIFO of master IDs for outstanding reads.
module ariele_arb_idfifo
  import ariele_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  mid_t                       push_id_i,
  input  logic                       pop_i,
  output mid_t                       head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  mid_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign full_o  = (r_count == FULL_CNT);
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  // Pointer and occupancy update; indices wrap naturally at DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_id_i;
  end

endmodule

// File: rtl/ariele_slave_arb.sv
// Round-robin arbiter sharing one MemSplit32 slave among N masters, with
// in-order routing of read responses back to their issuers.
module ariele_slave_arb
  import ariele_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 5,
  parameter int unsigned RD_DEPTH  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_MASTERS-1:0]    m_req_i,
  input  logic [N_MASTERS-1:0]    m_we_i,
  input  logic [32*N_MASTERS-1:0] m_addr_bi,
  input  logic [4*N_MASTERS-1:0]  m_be_i,
  input  logic [32*N_MASTERS-1:0] m_wdata_bi,
  output logic [N_MASTERS-1:0]    m_ack_o,
  output logic [N_MASTERS-1:0]    m_resp_o,
  output logic [31:0]             m_rdata_bo,
  output logic                    s_req_o,
  output logic                    s_we_o,
  output logic [31:0]             s_addr_bo,
  output logic [3:0]              s_be_o,
  output logic [31:0]             s_wdata_bo,
  input  logic                    s_ack_i,
  input  logic                    s_resp_i,
  input  logic [31:0]             s_rdata_bi,
  output logic                    err_o
);

  localparam int unsigned CW = $clog2(RD_DEPTH) + 1;
  localparam logic [CW-1:0] RD_FULL = RD_DEPTH[CW-1:0];

  mid_t r_rr_ptr;
  logic r_lock_vld;
  mid_t r_lock_id;
  logic r_err;

  logic [MAX_MASTERS-1:0] w_elig;
  pick_t                  w_pick;
  logic                   w_lock_req;
  logic                   w_vld;
  mid_t                   w_win;
  mid_t                   w_ptr_nxt;
  logic                   w_rd_full;
  logic                   w_we;
  logic [31:0]            w_addr;
  logic [3:0]             w_be;
  logic [31:0]            w_wdata;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  mid_t                   w_head;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [CW-1:0]          w_rd_count;

  ariele_arb_idfifo #(
    .DEPTH (RD_DEPTH)
  ) u_idfifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (w_push),
    .push_id_i (w_win),
    .pop_i     (w_pop),
    .head_o    (w_head),
    .full_o    (w_fifo_full),
    .empty_o   (w_fifo_empty),
    .count_o   (w_rd_count)
  );

  // Eligibility, round-robin pick, and lock override of the winner.
  always_comb begin
    w_rd_full  = (w_rd_count == RD_FULL);
    w_elig     = '0;
    w_lock_req = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      w_elig[k] = m_req_i[k] & (m_we_i[k] | ~w_rd_full);
      if (r_lock_id == mid_t'(k)) w_lock_req = m_req_i[k];
    end
    w_pick = rr_pick(w_elig, r_rr_ptr);
    if (r_lock_vld) begin
      w_vld = w_lock_req;
      w_win = r_lock_id;
    end else begin
      w_vld = w_pick.vld;
      w_win = w_pick.idx;
    end
    w_ptr_nxt = (w_win == mid_t'(N_MASTERS - 1)) ? '0 : w_win + 3'd1;
  end

  // Winner payload mux, handshake and response routing; all forced low in reset.
  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_be    = '0;
    w_wdata = '0;
    m_ack_o  = '0;
    m_resp_o = '0;
    w_accept = w_vld & s_ack_i & ~rst_i;
    w_pop    = s_resp_i & ~w_fifo_empty & ~rst_i;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (w_vld && (w_win == mid_t'(k))) begin
        w_we    = m_we_i[k];
        w_addr  = m_addr_bi[32*k +: 32];
        w_be    = m_be_i[4*k +: 4];
        w_wdata = m_wdata_bi[32*k +: 32];
        m_ack_o[k] = w_accept;
      end
      m_resp_o[k] = w_pop & (w_head == mid_t'(k));
    end
    w_push     = w_accept & ~w_we & ~w_fifo_full;
    s_req_o    = w_vld & ~rst_i;
    s_we_o     = w_we & ~rst_i;
    s_addr_bo  = rst_i ? '0 : w_addr;
    s_be_o     = rst_i ? '0 : w_be;
    s_wdata_bo = rst_i ? '0 : w_wdata;
    m_rdata_bo = rst_i ? '0 : s_rdata_bi;
    err_o      = r_err & ~rst_i;
  end

  // Round-robin pointer, grant lock while the slave stalls, sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_lock_vld <= 1'b0;
      r_lock_id  <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) r_rr_ptr <= w_ptr_nxt;
      r_lock_vld <= w_vld & ~s_ack_i;
      if (w_vld && !s_ack_i) r_lock_id <= w_win;
      if (s_resp_i && w_fifo_empty) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ariele_slave_arb.sv
// Directed bench for ariele_slave_arb (5 masters, 4 outstanding reads).
module tb_ariele_slave_arb;

  localparam int unsigned N = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   m_req, m_we;
  logic [32*N-1:0] m_addr, m_wdata;
  logic [4*N-1:0] m_be;
  logic [N-1:0]   m_ack, m_resp;
  logic [31:0]    m_rdata;
  logic           s_req, s_we;
  logic [31:0]    s_addr, s_wdata;
  logic [3:0]     s_be;
  logic           s_ack, s_resp;
  logic [31:0]    s_rdata;
  logic           err;

  int total = 0;
  int bad   = 0;

  logic [4:0] exp_rr [6];
  logic [4:0] exp_drain [4];

  ariele_slave_arb #(
    .N_MASTERS (N),
    .RD_DEPTH  (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .m_req_i    (m_req),
    .m_we_i     (m_we),
    .m_addr_bi  (m_addr),
    .m_be_i     (m_be),
    .m_wdata_bi (m_wdata),
    .m_ack_o    (m_ack),
    .m_resp_o   (m_resp),
    .m_rdata_bo (m_rdata),
    .s_req_o    (s_req),
    .s_we_o     (s_we),
    .s_addr_bo  (s_addr),
    .s_be_o     (s_be),
    .s_wdata_bo (s_wdata),
    .s_ack_i    (s_ack),
    .s_resp_i   (s_resp),
    .s_rdata_bi (s_rdata),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int k, input logic req, input logic we, input logic [31:0] addr);
    m_req[k]            = req;
    m_we[k]             = we;
    m_addr[32*k +: 32]  = addr;
    m_be[4*k +: 4]      = 4'hF;
    m_wdata[32*k +: 32] = addr ^ 32'h5555_5555;
  endtask

  function automatic logic [31:0] adr(input int k);
    return 32'h1000 + 32'(k) * 32'h10;
  endfunction

  initial begin
    exp_rr    = '{5'b00001, 5'b00010, 5'b01000, 5'b00001, 5'b00010, 5'b01000};
    exp_drain = '{5'b00100, 5'b00100, 5'b00100, 5'b00001};

    // Reset with every input active: all outputs must stay low.
    rst = 1'b1;
    m_req = '1; m_we = '1; m_addr = '1; m_wdata = '1; m_be = '1;
    s_ack = 1'b1; s_resp = 1'b1; s_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_req",  32'(s_req),  32'd0);
    chk("rst_s_addr", s_addr,      32'd0);
    chk("rst_m_ack",  32'(m_ack),  32'd0);
    chk("rst_m_resp", 32'(m_resp), 32'd0);
    chk("rst_rdata",  m_rdata,     32'd0);
    chk("rst_err",    32'(err),    32'd0);
    m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_be = '0;
    s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
    rst = 1'b0;
    #1;
    chk("idle_s_req", 32'(s_req), 32'd0);

    // Single master read with immediate ack, response three cycles later.
    step();
    set_m(2, 1'b1, 1'b0, 32'h100);
    s_ack = 1'b1;
    #1;
    chk("t1_addr", s_addr,      32'h100);
    chk("t1_ack",  32'(m_ack),  32'b00100);
    chk("t1_we",   32'(s_we),   32'd0);
    chk("t1_be",   32'(s_be),   32'hF);
    step();
    set_m(2, 1'b0, 1'b0, 32'h0);
    s_ack = 1'b0;
    step(); step(); step();
    s_resp = 1'b1; s_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_resp",  32'(m_resp), 32'b00100);
    chk("t1_rdata", m_rdata,     32'hDEAD_BEEF);
    step();
    s_resp = 1'b0;
    #1;
    chk("t1_resp_off", 32'(m_resp), 32'd0);
    chk("t1_err",      32'(err),    32'd0);

    // Round robin among masters 0, 1, 3 from a fresh pointer.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_m(0, 1'b1, 1'b1, adr(0));
    set_m(1, 1'b1, 1'b1, adr(1));
    set_m(3, 1'b1, 1'b1, adr(3));
    s_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_ack", 32'(m_ack), 32'(exp_rr[i]));
      step();
    end
    set_m(0, 1'b0, 1'b0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0);
    set_m(3, 1'b0, 1'b0, 32'h0);
    s_ack = 1'b0;
    // Pointer is now 4, so without the lock master 0 would win next.

    // Lock: master 1 stalled for 4 cycles while master 0 requests.
    set_m(1, 1'b1, 1'b1, adr(1));
    #1;
    chk("lk_addr_first", s_addr,     adr(1));
    chk("lk_noack_first", 32'(m_ack), 32'd0);
    step();
    set_m(0, 1'b1, 1'b1, adr(0));
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lk_addr",  s_addr,     adr(1));
      chk("lk_noack", 32'(m_ack), 32'd0);
      step();
    end
    s_ack = 1'b1;
    #1;
    chk("lk_ack1",  32'(m_ack), 32'b00010);
    chk("lk_addr1", s_addr,     adr(1));
    step();
    set_m(1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("lk_ack0",  32'(m_ack), 32'b00001);
    chk("lk_addr0", s_addr,     adr(0));
    step();
    set_m(0, 1'b0, 1'b0, 32'h0);
    s_ack = 1'b0;

    // FIFO full: four reads outstanding mask further reads but not writes.
    set_m(2, 1'b1, 1'b0, 32'h200);
    s_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ff_fill", 32'(m_ack), 32'b00100);
      step();
    end
    set_m(2, 1'b0, 1'b0, 32'h0);
    set_m(0, 1'b1, 1'b0, adr(0));
    set_m(1, 1'b1, 1'b1, adr(1));
    #1;
    chk("ff_wr_ack", 32'(m_ack), 32'b00010);
    chk("ff_wr_we",  32'(s_we),  32'd1);
    step();
    set_m(1, 1'b0, 1'b0, 32'h0);
    s_resp = 1'b1; s_rdata = 32'h11;
    #1;
    chk("ff_rd_masked", 32'(m_ack),  32'd0);
    chk("ff_s_req",     32'(s_req),  32'd0);
    chk("ff_pop",       32'(m_resp), 32'b00100);
    step();
    s_resp = 1'b0;
    #1;
    chk("ff_rd_ack", 32'(m_ack), 32'b00001);
    step();
    set_m(0, 1'b0, 1'b0, 32'h0);
    s_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_resp = 1'b1; s_rdata = 32'(i);
      #1;
      chk("ff_drain", 32'(m_resp), 32'(exp_drain[i]));
      step();
    end
    s_resp = 1'b0;

    // Ordering: master 3 then master 0; responses return in issue order.
    set_m(3, 1'b1, 1'b0, adr(3));
    s_ack = 1'b1;
    #1;
    chk("ord_ack3", 32'(m_ack), 32'b01000);
    step();
    set_m(3, 1'b0, 1'b0, 32'h0);
    set_m(0, 1'b1, 1'b0, adr(0));
    #1;
    chk("ord_ack0", 32'(m_ack), 32'b00001);
    step();
    set_m(0, 1'b0, 1'b0, 32'h0);
    s_ack = 1'b0;
    s_resp = 1'b1; s_rdata = 32'hA;
    #1;
    chk("ord_resp3", 32'(m_resp), 32'b01000);
    chk("ord_data3", m_rdata,     32'hA);
    step();
    s_rdata = 32'hB;
    #1;
    chk("ord_resp0", 32'(m_resp), 32'b00001);
    chk("ord_data0", m_rdata,     32'hB);
    step();
    s_resp = 1'b0;
    #1;
    chk("ord_idle", 32'(m_resp), 32'd0);

    // Reset with two reads outstanding; the late response is an error.
    set_m(4, 1'b1, 1'b0, adr(4));
    s_ack = 1'b1;
    #1;
    chk("er_ack4", 32'(m_ack), 32'b10000);
    step();
    set_m(4, 1'b0, 1'b0, 32'h0);
    set_m(2, 1'b1, 1'b0, adr(2));
    #1;
    chk("er_ack2", 32'(m_ack), 32'b00100);
    step();
    set_m(2, 1'b0, 1'b0, 32'h0);
    s_ack = 1'b0;
    #1;
    chk("er_pre", 32'(err), 32'd0);
    rst = 1'b1;
    #1;
    chk("er_rst_req", 32'(s_req), 32'd0);
    step();
    rst = 1'b0;
    step();
    s_resp = 1'b1; s_rdata = 32'hC;
    #1;
    chk("er_no_resp", 32'(m_resp), 32'd0);
    chk("er_not_yet", 32'(err),    32'd0);
    step();
    s_resp = 1'b0;
    #1;
    chk("er_set", 32'(err), 32'd1);
    step(); step();
    #1;
    chk("er_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("er_clear", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ariele_slave_arb.md
# ariele_slave_arb

Round-robin arbiter that shares one MemSplit32 slave port between N requesting masters and routes read responses back to their issuers. It is the per-slave arbitration stage of the ariele crossbar fabric, sitting between the master-side ports (tiles, udm) and a single slave (tile HPI, gpio). It tracks outstanding reads in an ID FIFO so that in-order slave responses return to the correct master.

## Interface
- N_MASTERS, 5: number of master ports (2..8)
- RD_DEPTH, 4: max outstanding reads per slave (power of two, 2..16)

- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- m_req_i  in  N_MASTERS  per-master request
- m_we_i  in  N_MASTERS  per-master write enable
- m_addr_bi  in  32*N_MASTERS  per-master address, master k at [32k+31:32k]
- m_be_i  in  4*N_MASTERS  per-master byte enables
- m_wdata_bi  in  32*N_MASTERS  per-master write data
- m_ack_o  out  N_MASTERS  request accepted, one-hot or zero
- m_resp_o  out  N_MASTERS  read response strobe, one-hot or zero
- m_rdata_bo  out  32  read data, shared by all masters, valid with m_resp_o
- s_req_o, s_we_o  out  1  slave request / write enable
- s_addr_bo  out  32  slave address
- s_be_o  out  4  slave byte enables
- s_wdata_bo  out  32  slave write data
- s_ack_i  in  1  slave accepted request
- s_resp_i  in  1  slave read response strobe
- s_rdata_bi  in  32  slave read data
- err_o  out  1  sticky: response received with no outstanding read

## Operation
- Handshake: a transfer is accepted in the cycle where req and ack are both high. Masters hold req and payload stable until ack. Writes get no response. Reads get exactly one resp, and responses return in issue order.
- Eligibility: master k is eligible when m_req_i[k] is high and either m_we_i[k]=1 or the ID FIFO is not full. Reads are masked while the FIFO is full; writes still proceed.
- Selection: the winner is the first eligible master at or after rr_ptr, wrapping modulo N_MASTERS. rr_ptr resets to 0.
- Grant lock: if s_req_o was high and s_ack_i was low in cycle t, then cycle t+1 re-grants the same master regardless of other requests. Registers: lock_vld, lock_id. The lock is released on ack.
- The winner's we/addr/be/wdata are muxed to the s_* outputs. s_req_o is high when a winner exists.
- On s_req_o & s_ack_i:
  - m_ack_o[winner] = s_ack_i, combinationally.
  - rr_ptr <= winner+1 mod N_MASTERS.
  - If the access is a read, winner ID is pushed to the FIFO.
- On s_resp_i:
  - The FIFO head is popped, m_resp_o[head] pulses, and m_rdata_bo = s_rdata_bi.
  - With the FIFO empty, the response is dropped, no m_resp_o fires, and err_o is set. err_o clears only on reset.
- Simultaneous push and pop in the same cycle are legal. When full, the pop frees a slot for the next cycle only; the full-mask uses the registered count.
- FIFO indices are log2(RD_DEPTH) bits and wrap naturally. The count is log2(RD_DEPTH)+1 bits.

## Timing
- Request path is combinational: m_req_i to s_req_o has 0-cycle latency. s_ack_i to m_ack_o has 0 cycles.
- Response path is combinational: s_resp_i to m_resp_o has 0 cycles.
- rr_ptr, lock and FIFO state update on the rising edge after acceptance or response.
- While rst_i is high, all outputs are forced to 0. This covers m_ack_o, m_resp_o, m_rdata_bo, all s_* outputs and err_o.
- Reset clears rr_ptr, lock, FIFO pointers, count and err_o. Reset mid-transaction discards outstanding reads; later slave responses for them raise err_o.
- Back-to-back acceptance is possible every cycle if the slave acks every cycle.

## Structure
- Package ariele_arb_pkg holds:
  - constants MAX_MASTERS=8 and MAX_RD_DEPTH=16
  - typedef mid_t (3-bit master ID)
  - function rr_pick(req_mask, ptr) returning a valid flag and an index
- Sub-module ariele_arb_idfifo (mid_t entries, depth RD_DEPTH) provides push, pop, head, full, empty and count.
- Top level contains the eligibility mask, the rr_pick call, the lock registers and the payload/response muxes.

## Test plan
- Single master: master 2 reads addr 0x100 with slave ack at once. Expect s_addr_bo=0x100 and m_ack_o=0b00100 in the same cycle. Slave resp 3 cycles later with data 0xDEADBEEF gives m_resp_o=0b00100 and m_rdata_bo=0xDEADBEEF.
- Round-robin: masters 0, 1 and 3 request continuously with the slave always acking. Grant order is 0,1,3,0,1,3 and no master is acked twice before the others.
- Lock: master 1 requests and the slave withholds ack for 4 cycles while master 0 asserts req. s_addr_bo stays on master 1 all 4 cycles. Master 0 is granted the cycle after master 1's ack.
- FIFO full (RD_DEPTH=4): 4 reads are accepted with no responses, then master 0 issues a read and master 1 a write. Only the write is acked. After one s_resp_i, the read is acked the next cycle.
- Ordering: master 3 read then master 0 read, responses 0xA then 0xB. Expect m_resp_o=0b01000 with 0xA, then 0b00001 with 0xB.
- Error/reset: 2 reads outstanding, rst_i pulsed for 1 cycle, then s_resp_i. Expect no m_resp_o and err_o=1 from the next cycle until the next reset.
